digest_stream_ctrl: RTL and testbench
=====================================

DIGEST_STREAM_CTRL -- requirements
Module: digest_stream_ctrl

Interface
REQ-001 Parameter WORD_W, default 32: width of one output word.
REQ-002 Parameter NWORDS, default 8: words per digest; digest width = WORD_W*NWORDS (256 at default).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 dig_valid  in  1  upstream digest available.
REQ-006 dig_ready  out  1  controller can accept a digest this cycle.
REQ-007 dig_data  in  WORD_W*NWORDS  digest; word 0 = bits [255:224], word 7 = bits [31:0].
REQ-008 out_valid  out  1  out_data holds a valid word.
REQ-009 out_ready  in  1  downstream accepts the word.
REQ-010 out_data  out  WORD_W  current word of the active digest.
REQ-011 out_idx  out  3  index (0..7) of the word on out_data.
REQ-012 out_last  out  1  high with out_valid when out_idx = NWORDS-1.
REQ-013 abort  in  1  synchronous flush request.
REQ-014 busy  out  1  high when the active or pending buffer is occupied.

Function
REQ-015 The block SHALL hold two digest buffers: active (being streamed) and pending (one-deep queue).
REQ-016 The FSM SHALL have two states: IDLE (active empty) and SEND (active occupied).
REQ-017 dig_ready SHALL equal ~pend_full & ~abort.
REQ-018 A digest SHALL be accepted on a rising edge where dig_valid & dig_ready.
REQ-019 Accept in IDLE: digest loads into active, word counter = 0, state -> SEND; out_valid high the cycle after the accepting edge (latency 1).
REQ-020 Accept in SEND: digest loads into pending, unless the same edge completes the last word with pending empty, in which case it loads directly into active.
REQ-021 A word transfers on an edge where out_valid & out_ready; the counter then increments by 1.
REQ-022 Counter is 3 bits; with no transfer it holds its value. out_valid, out_data and out_idx are stable until the word transfers.
REQ-023 Transfer with out_last: if pending is full, pending moves to active, counter = 0, state stays SEND with no bubble cycle; if a digest is accepted on that edge, it fills pending. Otherwise, state -> IDLE.
REQ-024 In SEND with out_ready low, all state SHALL hold (full backpressure, no word loss or duplication).
REQ-025 out_valid SHALL equal (state == SEND); out_data SHALL be active word[counter]. out_data is don't-care in IDLE but SHALL be driven to 0 there.
REQ-026 abort high at an edge: active and pending cleared, counter = 0, state -> IDLE; abort overrides any simultaneous word or digest handshake. dig_ready is low while abort is high.
REQ-027 busy SHALL equal (state == SEND) | pend_full.

Reset
REQ-028 On rst_n low, asynchronously: state = IDLE, counter = 0, pend_full = 0, both buffers = 0.
REQ-029 Outputs during reset: out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, busy = 0, dig_ready = 1 (with abort low).
REQ-030 Reset mid-stream SHALL discard the partially sent digest; there is no resume.

Structure
REQ-031 Shared package sha256_pkg: WORD_W, NWORDS, IDX_W = 3 and the FSM state encoding (IDLE = 0, SEND = 1).
REQ-032 One sub-module: digest_word_sel, a combinational NWORDS:1 selector from (buffer, index) to word, MSW first.
REQ-033 No other hierarchy; buffers, counter and FSM are local to digest_stream_ctrl.

Verification
REQ-034 Single digest 0x00000001_00000002_..._00000008, out_ready = 1: out_data 1..8 on consecutive cycles, out_idx 0..7, out_last on word 8; out_valid rises 1 cycle after acceptance; then IDLE.
REQ-035 Back-to-back digests A and B with B presented during A: word 7 of A is followed directly by word 0 of B on the next cycle; dig_ready is low only while pending is full.
REQ-036 out_ready toggled 1,0,0,1 on each word: exactly 8 transfers, no repeats, out_data held stable while out_ready is low.
REQ-037 abort asserted at out_idx = 3 with pending full: next cycle out_valid = 0, busy = 0, dig_ready = 1; a new digest then restarts at out_idx = 0.
REQ-038 rst_n pulsed low asynchronously mid-cycle at out_idx = 5: outputs go to reset values immediately, with no edge required.
REQ-039 Last-word transfer and new digest accept on the same edge with pending empty: the new digest streams starting the next cycle, word 0 first, and pend_full stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared widths and FSM encoding for the digest streaming controller.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int NWORDS = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/digest_word_sel.sv
// Combinational word selector: picks word idx from a packed digest, word 0 in the MSBs.
module digest_word_sel #(
    parameter int WORD_W = sha256_pkg::WORD_W,
    parameter int NWORDS = sha256_pkg::NWORDS,
    parameter int IDX_W  = sha256_pkg::IDX_W
) (
    input  logic [WORD_W*NWORDS-1:0] digest,
    input  logic [IDX_W-1:0]         idx,
    output logic [WORD_W-1:0]        word
);

    logic [WORD_W-1:0] words_s [NWORDS];

    for (genvar i = 0; i < NWORDS; i++) begin : g_split
        assign words_s[i] = digest[(NWORDS-1-i)*WORD_W +: WORD_W];
    end

    // Index into the unpacked word array
    always_comb begin
        word = words_s[idx];
    end

endmodule

// File: rtl/digest_stream_ctrl.sv
// Streams wide digests out one word at a time, with a one-deep pending queue
// so a following digest can start on the cycle after the previous last word.
module digest_stream_ctrl
    import sha256_pkg::state_t;
    import sha256_pkg::IDLE;
    import sha256_pkg::SEND;
    import sha256_pkg::IDX_W;
#(
    parameter int WORD_W = sha256_pkg::WORD_W,
    parameter int NWORDS = sha256_pkg::NWORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dig_valid,
    output logic                     dig_ready,
    input  logic [WORD_W*NWORDS-1:0] dig_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    input  logic                     abort,
    output logic                     busy
);

    localparam int DW = WORD_W * NWORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t            state_r;
    logic [DW-1:0]     active_r;
    logic [DW-1:0]     pend_r;
    logic              pend_full_r;
    logic [IDX_W-1:0]  cnt_r;
    logic [WORD_W-1:0] sel_word_s;
    logic              accept_s;
    logic              xfer_s;
    logic              last_xfer_s;

    digest_word_sel #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .IDX_W  (IDX_W)
    ) u_word_sel (
        .digest (active_r),
        .idx    (cnt_r),
        .word   (sel_word_s)
    );

    assign dig_ready   = ~pend_full_r & ~abort;
    assign accept_s    = dig_valid & dig_ready;
    assign xfer_s      = (state_r == SEND) & out_ready;
    assign last_xfer_s = xfer_s & (cnt_r == LAST_IDX);

    assign out_valid = (state_r == SEND);
    assign out_idx   = cnt_r;
    assign out_last  = (state_r == SEND) & (cnt_r == LAST_IDX);
    assign busy      = (state_r == SEND) | pend_full_r;

    // Hold out_data at zero while idle rather than exposing stale buffer content
    always_comb begin
        if (state_r == SEND) begin
            out_data = sel_word_s;
        end else begin
            out_data = {WORD_W{1'b0}};
        end
    end

    // Buffer, counter and FSM update; abort beats any simultaneous handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            active_r    <= {DW{1'b0}};
            pend_r      <= {DW{1'b0}};
            pend_full_r <= 1'b0;
            cnt_r       <= {IDX_W{1'b0}};
        end else if (abort) begin
            state_r     <= IDLE;
            active_r    <= {DW{1'b0}};
            pend_r      <= {DW{1'b0}};
            pend_full_r <= 1'b0;
            cnt_r       <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        active_r <= dig_data;
                        cnt_r    <= {IDX_W{1'b0}};
                        state_r  <= SEND;
                    end
                end
                SEND: begin
                    if (last_xfer_s) begin
                        cnt_r <= {IDX_W{1'b0}};
                        // dig_ready is low whenever pending is full, so no accept here
                        if (pend_full_r) begin
                            active_r    <= pend_r;
                            pend_r      <= {DW{1'b0}};
                            pend_full_r <= 1'b0;
                        end else if (accept_s) begin
                            active_r <= dig_data;
                        end else begin
                            active_r <= {DW{1'b0}};
                            state_r  <= IDLE;
                        end
                    end else begin
                        if (xfer_s) begin
                            cnt_r <= cnt_r + ONE_IDX;
                        end
                        if (accept_s) begin
                            pend_r      <= dig_data;
                            pend_full_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    active_r    <= {DW{1'b0}};
                    pend_r      <= {DW{1'b0}};
                    pend_full_r <= 1'b0;
                    cnt_r       <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digest_stream_ctrl.sv
// Directed self-checking bench for digest_stream_ctrl at default parameters.
module tb_digest_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         abort;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    digest_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig_data  (dig_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Digest whose word i (word 0 in the MSBs) equals base + i
    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) d[(7-i)*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks the visible word i of a digest built from base, then lets it transfer
    task automatic expect_word(input string tag, input logic [31:0] base, input int i);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(base + 32'(i)));
        chk({tag, "_idx"}, 64'(out_idx), 64'(i));
        chk({tag, "_last"}, 64'(out_last), (i == 7) ? 64'd1 : 64'd0);
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        dig_valid = 1'b0;
        dig_data  = '0;
        out_ready = 1'b1;
        abort     = 1'b0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(dig_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single digest, latency 1, words 1..8
        chk("s_pre_valid", 64'(out_valid), 64'd0);
        dig_valid = 1'b1;
        dig_data  = mk(32'd1);
        step();
        dig_valid = 1'b0;
        for (int i = 0; i < 8; i++) expect_word("single", 32'd1, i);
        chk("s_idle_valid", 64'(out_valid), 64'd0);
        chk("s_idle_busy", 64'(busy), 64'd0);
        chk("s_idle_data", 64'(out_data), 64'd0);

        // Back-to-back A then B, no bubble between A7 and B0
        dig_valid = 1'b1;
        dig_data  = mk(32'h10);
        step();
        dig_data = mk(32'h20);
        chk("b2b_ready_free", 64'(dig_ready), 64'd1);
        step();
        dig_valid = 1'b0;
        chk("b2b_ready_full", 64'(dig_ready), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
        for (int i = 1; i < 8; i++) expect_word("b2b_a", 32'h10, i);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready_drain", 64'(dig_ready), 64'd1);
            expect_word("b2b_b", 32'h20, i);
        end
        chk("b2b_idle", 64'(out_valid), 64'd0);

        // Backpressure: two stalled cycles before every transfer
        dig_valid = 1'b1;
        dig_data  = mk(32'h30);
        out_ready = 1'b0;
        step();
        dig_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                chk("bp_hold_data", 64'(out_data), 64'(32'h30 + 32'(i)));
                chk("bp_hold_idx", 64'(out_idx), 64'(i));
                step();
            end
            out_ready = 1'b1;
            expect_word("bp", 32'h30, i);
            out_ready = 1'b0;
        end
        chk("bp_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Abort at idx 3 with pending full, then restart from idx 0
        dig_valid = 1'b1;
        dig_data  = mk(32'h40);
        step();
        dig_data = mk(32'h50);
        step();
        dig_valid = 1'b0;
        step();
        step();
        chk("ab_idx3", 64'(out_idx), 64'd3);
        chk("ab_pend_full", 64'(dig_ready), 64'd0);
        abort = 1'b1;
        #1;
        chk("ab_ready_low", 64'(dig_ready), 64'd0);
        step();
        abort = 1'b0;
        #1;
        chk("ab_valid", 64'(out_valid), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_ready", 64'(dig_ready), 64'd1);
        dig_valid = 1'b1;
        dig_data  = mk(32'h60);
        step();
        dig_valid = 1'b0;
        for (int i = 0; i < 8; i++) expect_word("ab_new", 32'h60, i);
        chk("ab_no_stale", 64'(out_valid), 64'd0);

        // Last-word transfer and accept on the same edge with pending empty
        dig_valid = 1'b1;
        dig_data  = mk(32'h70);
        step();
        dig_valid = 1'b0;
        for (int i = 0; i < 7; i++) expect_word("lw_f", 32'h70, i);
        chk("lw_f_last", 64'(out_last), 64'd1);
        dig_valid = 1'b1;
        dig_data  = mk(32'h80);
        step();
        dig_valid = 1'b0;
        chk("lw_pend_empty", 64'(dig_ready), 64'd1);
        for (int i = 0; i < 8; i++) expect_word("lw_g", 32'h80, i);
        chk("lw_idle", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream at idx 5
        dig_valid = 1'b1;
        dig_data  = mk(32'h90);
        step();
        dig_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("ar_idx5", 64'(out_idx), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_idx", 64'(out_idx), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        chk("ar_last", 64'(out_last), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_ready", 64'(dig_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_no_resume", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
